core_result_hub: RTL
====================

Name: core_result_hub

Overview:
- Collects per-core result pairs from NUM_CORES child Processor cores into registered slots.
- Replaces the purely combinational value mux and flag AND between child cores and the parent core.
- Adds the following over a plain mux:
  - edge-triggered capture, so child values stay stable after their flag rises;
  - a registered parent read port;
  - a per-core enable mask, done counting, epoch clear and overrun detection.
- Sits in the multicore top between the child core buffer outputs and the parent core.

Parameters:
- NUM_CORES, 31, number of child cores (1..64).
- DATA_W, 32, width of each result value.
- ADDR_W, 5, slot address width; must satisfy 2**ADDR_W >= NUM_CORES.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- child_flag  in  NUM_CORES  per-core "result ready" level from each child.
- child_val_1  in  NUM_CORES*DATA_W  flattened first result; core i occupies bits [i*DATA_W +: DATA_W].
- child_val_2  in  NUM_CORES*DATA_W  flattened second result, same packing.
- core_mask  in  NUM_CORES  1 = core participates; 0 = core is ignored and counted as done.
- clr  in  1  single-cycle epoch clear.
- rd_en  in  1  parent read request.
- rd_addr  in  ADDR_W  slot to read.
- rd_val_1  out  DATA_W  registered slot value 1.
- rd_val_2  out  DATA_W  registered slot value 2.
- rd_slot_valid  out  1  registered valid bit of the slot that was read.
- rd_ack  out  1  one-cycle pulse, one cycle after rd_en.
- rd_err  out  1  one-cycle pulse, one cycle after rd_en with rd_addr >= NUM_CORES.
- all_done  out  1  registered: every masked-in slot is valid.
- done_count  out  ADDR_W+1  registered count of valid masked-in slots.
- overrun  out  1  sticky: a flag edge arrived on an already-valid slot.

Behaviour:
- Reset (Reset=0, async): all slot data, valid bits, flag_prev, rd_* outputs, done_count, all_done and overrun go to 0.
- Edge detect:
  - flag_prev[i] <= child_flag[i] every cycle.
  - rise[i] = child_flag[i] & ~flag_prev[i].
  - A flag already high when reset deasserts is seen as a rise in the first cycle.
- Capture for core i, when rise[i] & core_mask[i] & ~valid[i]:
  - slot_1[i] and slot_2[i] latch the child values on that edge;
  - valid[i] <= 1.
  - Captured data never changes afterwards until clr or reset.
- Overrun: when rise[i] & core_mask[i] & valid[i], no capture occurs and overrun <= 1 (sticky).
- Masked-out core (core_mask[i]=0): never captured; edges ignored; no overrun.
- clr:
  - All valid bits and overrun go to 0; slot data is retained but stale.
  - A rise in the same cycle as clr is captured into the new epoch: valid[i]=1 after that edge.
  - flag_prev is not cleared by clr.
- Read:
  - rd_en at cycle N gives rd_val_1, rd_val_2, rd_slot_valid and rd_ack=1 at cycle N+1.
  - rd_val_*/rd_slot_valid hold their value when rd_en=0; rd_ack and rd_err are 0 when rd_en=0.
  - Out-of-range address: rd_val_*=0, rd_slot_valid=0, rd_ack=1, rd_err=1.
  - Reading a slot in the same cycle it is captured or cleared returns the pre-edge contents (read-before-write).
- Status:
  - all_done and done_count are computed from the next-state valid bits and core_mask, and registered.
  - They therefore update in the same edge as the capture or clr that changes them.
  - all_done = &(valid | ~core_mask).
  - done_count = popcount(valid & core_mask).
  - With core_mask all zero, all_done=1 and done_count=0 from the first edge after reset.
- core_mask changes take effect immediately; valid bits of newly masked-out cores are kept but excluded from status.

Test Plan:
- Reset → raise child_flag[3] with val_1=0x11, val_2=0x22 → slot 3 valid after the edge, done_count=1, all_done=0; rd_en at rd_addr=3 → next cycle rd_val_1=0x11, rd_val_2=0x22, rd_slot_valid=1, rd_ack=1.
- All 31 flags rise in one cycle, core_mask all ones → all_done=1 and done_count=31 after that edge; reading slot 30 returns the core-30 values.
- Core 5 flag falls then rises again with new data → slot 5 keeps its original data and overrun=1; clr → overrun=0, done_count decrements, core-5 valid=0.
- clr asserted in the same cycle as a core-7 rise → after the edge only valid[7]=1, done_count=1.
- core_mask=0x0000_0003 and cores 0 and 1 captured → all_done=1 and done_count=2; an edge on core 9 is ignored.
- rd_en with rd_addr=31 (NUM_CORES=31) → next cycle rd_err=1, rd_ack=1, rd_val_*=0; Reset pulsed low mid-operation → all outputs 0 immediately, without waiting for Clk.

Source files
------------

// File: rtl/core_result_hub.sv
// Collects per-core result pairs into registered slots on the rising edge of each child's flag.
// Provides a registered parent read port, done status, an epoch clear and sticky overrun detection.
module core_result_hub #(
  parameter int NUM_CORES = 31,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_CORES-1:0]        child_flag_i,
  input  logic [NUM_CORES*DATA_W-1:0] child_val_1_i,
  input  logic [NUM_CORES*DATA_W-1:0] child_val_2_i,
  input  logic [NUM_CORES-1:0]        core_mask_i,
  input  logic                        clr_i,
  input  logic                        rd_en_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [DATA_W-1:0]           rd_val_1_o,
  output logic [DATA_W-1:0]           rd_val_2_o,
  output logic                        rd_slot_valid_o,
  output logic                        rd_ack_o,
  output logic                        rd_err_o,
  output logic                        all_done_o,
  output logic [ADDR_W:0]             done_count_o,
  output logic                        overrun_o
);

  localparam logic [ADDR_W:0] NUM_CORES_W = NUM_CORES;

  logic [NUM_CORES-1:0] flag_prev_q;
  logic [NUM_CORES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]    slot_1_q [NUM_CORES];
  logic [DATA_W-1:0]    slot_2_q [NUM_CORES];

  logic [NUM_CORES-1:0] rise, valid_base, capture;
  logic                 overrun_q, overrun_d;
  logic                 all_done_q, all_done_d;
  logic [ADDR_W:0]      done_count_q, done_count_d;

  logic [DATA_W-1:0]    rd_val_1_q, rd_val_1_d;
  logic [DATA_W-1:0]    rd_val_2_q, rd_val_2_d;
  logic                 rd_slot_valid_q, rd_slot_valid_d;
  logic                 rd_ack_q, rd_err_q, rd_err_d;
  logic                 rd_in_range;

  // clr empties the epoch first, so a same-cycle rise lands in the new epoch and never counts as overrun.
  always_comb begin
    rise         = child_flag_i & ~flag_prev_q;
    valid_base   = clr_i ? '0 : valid_q;
    capture      = rise & core_mask_i & ~valid_base;
    valid_d      = valid_base | capture;
    overrun_d    = clr_i ? 1'b0 : (overrun_q | (|(rise & core_mask_i & valid_base)));
    all_done_d   = &(valid_d | ~core_mask_i);
    done_count_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_count_d = done_count_d + {{ADDR_W{1'b0}}, valid_d[i] & core_mask_i[i]};
    end
  end

  // Read port samples pre-edge slot state; out-of-range addresses return zeros with an error pulse.
  always_comb begin
    rd_in_range     = ({1'b0, rd_addr_i} < NUM_CORES_W);
    rd_val_1_d      = rd_val_1_q;
    rd_val_2_d      = rd_val_2_q;
    rd_slot_valid_d = rd_slot_valid_q;
    rd_err_d        = 1'b0;
    if (rd_en_i) begin
      if (rd_in_range) begin
        rd_val_1_d      = slot_1_q[rd_addr_i];
        rd_val_2_d      = slot_2_q[rd_addr_i];
        rd_slot_valid_d = valid_q[rd_addr_i];
      end else begin
        rd_val_1_d      = '0;
        rd_val_2_d      = '0;
        rd_slot_valid_d = 1'b0;
        rd_err_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_prev_q     <= '0;
      valid_q         <= '0;
      overrun_q       <= 1'b0;
      all_done_q      <= 1'b0;
      done_count_q    <= '0;
      rd_val_1_q      <= '0;
      rd_val_2_q      <= '0;
      rd_slot_valid_q <= 1'b0;
      rd_ack_q        <= 1'b0;
      rd_err_q        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_1_q[i] <= '0;
        slot_2_q[i] <= '0;
      end
    end else begin
      flag_prev_q     <= child_flag_i;
      valid_q         <= valid_d;
      overrun_q       <= overrun_d;
      all_done_q      <= all_done_d;
      done_count_q    <= done_count_d;
      rd_val_1_q      <= rd_val_1_d;
      rd_val_2_q      <= rd_val_2_d;
      rd_slot_valid_q <= rd_slot_valid_d;
      rd_ack_q        <= rd_en_i;
      rd_err_q        <= rd_err_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture[i]) begin
          slot_1_q[i] <= child_val_1_i[i*DATA_W +: DATA_W];
          slot_2_q[i] <= child_val_2_i[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign rd_val_1_o      = rd_val_1_q;
  assign rd_val_2_o      = rd_val_2_q;
  assign rd_slot_valid_o = rd_slot_valid_q;
  assign rd_ack_o        = rd_ack_q;
  assign rd_err_o        = rd_err_q;
  assign all_done_o      = all_done_q;
  assign done_count_o    = done_count_q;
  assign overrun_o       = overrun_q;

endmodule
